// File: rtl/rtc_timekeeper_if.sv
// Control, load and display bundle of the real-time-clock core.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_timekeeper_if;
    logic       en;
    logic       mode_12h;
    logic       load;
    logic [4:0] load_hh;
    logic [5:0] load_mm;
    logic [5:0] load_ss;
    logic       load_err;
    logic       sec_tick;
    logic       day_tick;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic       pm;
`ifdef RTC_ALARM_EN
    logic       alarm;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;
    logic       alarm_arm;
    logic       alarm_ack;
`endif

    modport master (
        output en, mode_12h, load, load_hh, load_mm, load_ss,
`ifdef RTC_ALARM_EN
        output alarm_hh, alarm_mm, alarm_arm, alarm_ack,
        input  alarm,
`endif
        input  load_err, sec_tick, day_tick, s1, s2, m1, m2, h1, h2, pm
    );

    modport slave (
        input  en, mode_12h, load, load_hh, load_mm, load_ss,
`ifdef RTC_ALARM_EN
        input  alarm_hh, alarm_mm, alarm_arm, alarm_ack,
        output alarm,
`endif
        output load_err, sec_tick, day_tick, s1, s2, m1, m2, h1, h2, pm
    );
endinterface

// File: rtl/rtc_timekeeper.sv
// Real-time clock: prescaled 1 Hz tick, loadable hh:mm:ss, BCD display in 24 h or 12 h form.
// Optional alarm compare enabled by defining RTC_ALARM_EN.
module rtc_timekeeper #(
    parameter int CLK_PER_SEC = 100,
    parameter int RESET_HOUR  = 0
) (
    input  logic clk,
    input  logic rst_n,
    rtc_timekeeper_if.slave bus
);

    localparam int             PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [4:0]     HOUR_INIT  = 5'(RESET_HOUR);

    logic [PW-1:0] presc, presc_nxt;
    logic [4:0]    hour, hour_nxt;
    logic [5:0]    min, min_nxt;
    logic [5:0]    sec, sec_nxt;
    logic          sec_tick_r, sec_tick_nxt;
    logic          day_tick_r, day_tick_nxt;
    logic          load_err_r, load_err_nxt;
    logic          load_ok;
    logic [4:0]    hour_disp;
`ifdef RTC_ALARM_EN
    logic          alarm_r, alarm_nxt;
    logic          alarm_hit;
`endif

    // Binary 0..59 to two BCD digits {tens, ones}
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'(r)};
    endfunction

    assign load_ok = (bus.load_hh <= 5'd23) && (bus.load_mm <= 6'd59) && (bus.load_ss <= 6'd59);

    always_comb begin
        presc_nxt    = presc;
        hour_nxt     = hour;
        min_nxt      = min;
        sec_nxt      = sec;
        sec_tick_nxt = 1'b0;
        day_tick_nxt = 1'b0;
        load_err_nxt = 1'b0;
        // A load, accepted or rejected, owns the cycle: a coincident terminal count is dropped
        if (bus.load) begin
            if (load_ok) begin
                hour_nxt  = bus.load_hh;
                min_nxt   = bus.load_mm;
                sec_nxt   = bus.load_ss;
                presc_nxt = '0;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (bus.en) begin
            if (presc == PRESC_LAST) begin
                presc_nxt    = '0;
                sec_tick_nxt = 1'b1;
                day_tick_nxt = (hour == 5'd23) && (min == 6'd59) && (sec == 6'd59);
                if (sec == 6'd59) begin
                    sec_nxt = 6'd0;
                    if (min == 6'd59) begin
                        min_nxt  = 6'd0;
                        hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                    end else begin
                        min_nxt = min + 6'd1;
                    end
                end else begin
                    sec_nxt = sec + 6'd1;
                end
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end
    end

`ifdef RTC_ALARM_EN
    // Only a counted second can raise the alarm; loads never do
    assign alarm_hit = sec_tick_nxt && (bus.alarm_hh <= 5'd23) && (bus.alarm_mm <= 6'd59) &&
                       (hour_nxt == bus.alarm_hh) && (min_nxt == bus.alarm_mm) && (sec_nxt == 6'd0);

    always_comb begin
        alarm_nxt = alarm_r;
        if (!bus.alarm_arm || bus.alarm_ack) begin
            alarm_nxt = 1'b0;
        end else if (alarm_hit) begin
            alarm_nxt = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            hour       <= HOUR_INIT;
            min        <= 6'd0;
            sec        <= 6'd0;
            sec_tick_r <= 1'b0;
            day_tick_r <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            hour       <= hour_nxt;
            min        <= min_nxt;
            sec        <= sec_nxt;
            sec_tick_r <= sec_tick_nxt;
            day_tick_r <= day_tick_nxt;
            load_err_r <= load_err_nxt;
        end
    end

`ifdef RTC_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_r <= 1'b0;
        end else begin
            alarm_r <= alarm_nxt;
        end
    end

    assign bus.alarm = alarm_r;
`endif

    // 12 h display maps 0 -> 12 and 13..23 -> 1..11; state stays 24 h
    always_comb begin
        hour_disp = hour;
        if (bus.mode_12h) begin
            if (hour == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour > 5'd12) begin
                hour_disp = hour - 5'd12;
            end
        end
    end

    assign {bus.s2, bus.s1} = to_bcd(sec);
    assign {bus.m2, bus.m1} = to_bcd(min);
    assign {bus.h2, bus.h1} = to_bcd({1'b0, hour_disp});
    assign bus.pm           = (hour >= 5'd12);
    assign bus.sec_tick     = sec_tick_r;
    assign bus.day_tick     = day_tick_r;
    assign bus.load_err     = load_err_r;

endmodule
